// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and pipeline control/counter outputs of the hazard controller
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic ID_UsesRs, ID_UsesRt, EX_MemRead, ID_Branch_Taken, Mem_Busy, Cnt_Clr;
  logic PC_WE, IF_ID_WE, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Busy_State;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt, Freeze_Cnt;
  modport master(
    output ID_Rs, ID_Rt, EX_Rt, ID_UsesRs, ID_UsesRt, EX_MemRead, ID_Branch_Taken, Mem_Busy, Cnt_Clr,
    input PC_WE, IF_ID_WE, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Busy_State, Stall_Cnt, Flush_Cnt, Freeze_Cnt
  );
  modport slave(
    input ID_Rs, ID_Rt, EX_Rt, ID_UsesRs, ID_UsesRt, EX_MemRead, ID_Branch_Taken, Mem_Busy, Cnt_Clr,
    output PC_WE, IF_ID_WE, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Busy_State, Stall_Cnt, Flush_Cnt, Freeze_Cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and memory freeze control with saturating event counters
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic Reset,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, LSTALL} state_e;
  state_e state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;
  logic haz, stall, run;
  assign haz = bus.EX_MemRead && bus.EX_Rt != 5'd0 &&
               ((bus.ID_UsesRs && bus.ID_Rs == bus.EX_Rt) || (bus.ID_UsesRt && bus.ID_Rt == bus.EX_Rt));
  assign stall = state_q == LSTALL || haz;
  assign run = !Reset && !bus.Mem_Busy && !stall;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= RUN;
      rem_q <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
    end
  end
  // the hazard cycle itself is the first bubble, so LSTALL covers the remaining LOAD_STALL-1
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    if (!bus.Mem_Busy) begin
      if (state_q == LSTALL) begin
        rem_d = rem_q - 3'd1;
        state_d = rem_q == 3'd1 ? RUN : LSTALL;
      end else if (haz && LOAD_STALL > 1) begin
        state_d = LSTALL;
        rem_d = 3'(LOAD_STALL - 1);
      end
    end
  end
  always_comb begin
    bus.PC_WE = run;
    bus.IF_ID_WE = run;
    bus.IF_ID_Flush = Reset || (run && bus.ID_Branch_Taken);
    bus.ID_EX_Bubble = Reset || (!bus.Mem_Busy && stall);
    bus.Pipe_Freeze = !Reset && bus.Mem_Busy;
    bus.Busy_State = state_q == LSTALL;
  end
  always_ff @(posedge CLK) begin
    if (Reset || bus.Cnt_Clr) begin
      stall_q <= '0;
      flush_q <= '0;
      freeze_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(bus.ID_EX_Bubble && stall_q != '1);
      flush_q <= flush_q + CNT_W'(bus.IF_ID_Flush && flush_q != '1);
      freeze_q <= freeze_q + CNT_W'(bus.Pipe_Freeze && freeze_q != '1);
    end
  end
  assign bus.Stall_Cnt = stall_q;
  assign bus.Flush_Cnt = flush_q;
  assign bus.Freeze_Cnt = freeze_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: three configurations driven in lockstep and checked against a stall-budget model
module tb_pipe_hazard_ctrl;
  typedef struct {
    logic r, busy, br, clr, mr;
    logic [4:0] ex, rs;
    logic urs;
    logic [4:0] rt;
    logic urt;
  } stim_t;
  typedef struct {
    stim_t s;
    logic [4:0] exp;
  } vec_t;
  logic CLK = 1'b0;
  logic Reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic uses_rs, uses_rt, mem_read, br_tk, mem_busy, cnt_clr;
  always #5 CLK = ~CLK;
  pipe_hazard_ctrl_if #(.CNT_W(16)) ia();
  pipe_hazard_ctrl_if #(.CNT_W(16)) ib();
  pipe_hazard_ctrl_if #(.CNT_W(2)) ic();
  pipe_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dut_a (.CLK(CLK), .Reset(Reset), .bus(ia));
  pipe_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) dut_b (.CLK(CLK), .Reset(Reset), .bus(ib));
  pipe_hazard_ctrl #(.LOAD_STALL(7), .CNT_W(2)) dut_c (.CLK(CLK), .Reset(Reset), .bus(ic));
  assign {ia.ID_Rs, ia.ID_Rt, ia.EX_Rt, ia.ID_UsesRs, ia.ID_UsesRt, ia.EX_MemRead, ia.ID_Branch_Taken, ia.Mem_Busy, ia.Cnt_Clr} =
         {id_rs, id_rt, ex_rt, uses_rs, uses_rt, mem_read, br_tk, mem_busy, cnt_clr};
  assign {ib.ID_Rs, ib.ID_Rt, ib.EX_Rt, ib.ID_UsesRs, ib.ID_UsesRt, ib.EX_MemRead, ib.ID_Branch_Taken, ib.Mem_Busy, ib.Cnt_Clr} =
         {id_rs, id_rt, ex_rt, uses_rs, uses_rt, mem_read, br_tk, mem_busy, cnt_clr};
  assign {ic.ID_Rs, ic.ID_Rt, ic.EX_Rt, ic.ID_UsesRs, ic.ID_UsesRt, ic.EX_MemRead, ic.ID_Branch_Taken, ic.Mem_Busy, ic.Cnt_Clr} =
         {id_rs, id_rt, ex_rt, uses_rs, uses_rt, mem_read, br_tk, mem_busy, cnt_clr};
  logic [4:0] ctl [3];
  logic bsy [3];
  logic [31:0] sc_o [3], fc_o [3], zc_o [3];
  assign ctl[0] = {ia.PC_WE, ia.IF_ID_WE, ia.IF_ID_Flush, ia.ID_EX_Bubble, ia.Pipe_Freeze};
  assign ctl[1] = {ib.PC_WE, ib.IF_ID_WE, ib.IF_ID_Flush, ib.ID_EX_Bubble, ib.Pipe_Freeze};
  assign ctl[2] = {ic.PC_WE, ic.IF_ID_WE, ic.IF_ID_Flush, ic.ID_EX_Bubble, ic.Pipe_Freeze};
  assign bsy[0] = ia.Busy_State;
  assign bsy[1] = ib.Busy_State;
  assign bsy[2] = ic.Busy_State;
  assign sc_o[0] = 32'(ia.Stall_Cnt);
  assign sc_o[1] = 32'(ib.Stall_Cnt);
  assign sc_o[2] = 32'(ic.Stall_Cnt);
  assign fc_o[0] = 32'(ia.Flush_Cnt);
  assign fc_o[1] = 32'(ib.Flush_Cnt);
  assign fc_o[2] = 32'(ic.Flush_Cnt);
  assign zc_o[0] = 32'(ia.Freeze_Cnt);
  assign zc_o[1] = 32'(ib.Freeze_Cnt);
  assign zc_o[2] = 32'(ic.Freeze_Cnt);
  int ls [3] = '{1, 3, 7};
  int cmax [3] = '{65535, 65535, 3};
  int left [3], msc [3], mfc [3], mzc [3];
  int vectors = 0, miscompares = 0;
  function automatic bit haz();
    return mem_read && ex_rt != 5'd0 && ((uses_rs && id_rs == ex_rt) || (uses_rt && id_rt == ex_rt));
  endfunction
  // {PC_WE, IF_ID_WE, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze} from the priority list
  function automatic logic [4:0] mctl(int k);
    if (Reset) return 5'b00110;
    if (mem_busy) return 5'b00001;
    if (left[k] > 0 || haz()) return 5'b00010;
    if (br_tk) return 5'b11100;
    return 5'b11000;
  endfunction
  function automatic int sat(int v, int inc, int mx);
    return (v + inc > mx) ? mx : v + inc;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask
  task automatic step(input stim_t s, input int exp_a);
    logic [4:0] mc [3];
    {Reset, mem_busy, br_tk, cnt_clr, mem_read} = {s.r, s.busy, s.br, s.clr, s.mr};
    {ex_rt, id_rs, uses_rs, id_rt, uses_rt} = {s.ex, s.rs, s.urs, s.rt, s.urt};
    #2;
    if (exp_a >= 0) chk("table_ctl", 0, 32'(ctl[0]), 32'(exp_a));
    for (int k = 0; k < 3; k++) begin
      mc[k] = mctl(k);
      chk("ctl", k, 32'(ctl[k]), 32'(mc[k]));
      chk("busy_state", k, 32'(bsy[k]), 32'(left[k] > 0));
      chk("stall_cnt", k, sc_o[k], 32'(msc[k]));
      chk("flush_cnt", k, fc_o[k], 32'(mfc[k]));
      chk("freeze_cnt", k, zc_o[k], 32'(mzc[k]));
    end
    @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      if (s.r) begin
        left[k] = 0; msc[k] = 0; mfc[k] = 0; mzc[k] = 0;
      end else begin
        if (s.clr) begin
          msc[k] = 0; mfc[k] = 0; mzc[k] = 0;
        end else begin
          msc[k] = sat(msc[k], int'(mc[k][1]), cmax[k]);
          mfc[k] = sat(mfc[k], int'(mc[k][2]), cmax[k]);
          mzc[k] = sat(mzc[k], int'(mc[k][0]), cmax[k]);
        end
        if (s.busy) ;
        else if (left[k] > 0) left[k]--;
        else if (haz()) left[k] = ls[k] - 1;
      end
    end
    #1;
  endtask
  stim_t idle, rst, hz, brs, s;
  vec_t tbl [12];
  initial begin
    idle = '{0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0};
    rst = idle; rst.r = 1;
    hz = '{0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0};
    brs = idle; brs.br = 1;
    tbl[0] = '{rst, 5'b00110};
    tbl[1] = '{rst, 5'b00110};
    tbl[2] = '{idle, 5'b11000};
    tbl[3] = '{hz, 5'b00010};
    tbl[4] = '{idle, 5'b11000};
    tbl[5] = '{brs, 5'b11100};
    tbl[6] = '{'{0, 0, 1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0}, 5'b00010};
    tbl[7] = '{'{0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0}, 5'b11000};
    tbl[8] = '{'{0, 0, 0, 0, 1, 5'd5, 5'd0, 0, 5'd5, 0}, 5'b11000};
    tbl[9] = '{'{0, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0}, 5'b00001};
    tbl[10] = '{'{0, 0, 0, 0, 1, 5'd7, 5'd0, 0, 5'd7, 1}, 5'b00010};
    tbl[11] = '{idle, 5'b11000};
    {Reset, mem_busy, br_tk, cnt_clr, mem_read, uses_rs, uses_rt} = 7'b1000000;
    {id_rs, id_rt, ex_rt} = '0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 12; i++) step(tbl[i].s, int'(tbl[i].exp));
    chk("a_stall_total", 0, sc_o[0], 32'd3);
    chk("a_flush_total", 0, fc_o[0], 32'd1);
    chk("a_freeze_total", 0, zc_o[0], 32'd1);
    step(rst, -1);
    step(hz, -1);
    s = idle; s.busy = 1;
    step(s, -1);
    step(s, -1);
    for (int i = 0; i < 3; i++) step(idle, -1);
    chk("b_stall_freeze", 1, sc_o[1], 32'd3);
    chk("b_freeze_total", 1, zc_o[1], 32'd2);
    chk("b_back_to_run", 1, 32'(bsy[1]), 32'd0);
    step(rst, -1);
    for (int i = 0; i < 5; i++) step(brs, -1);
    chk("c_flush_sat", 2, fc_o[2], 32'd3);
    chk("a_flush_five", 0, fc_o[0], 32'd5);
    s = brs; s.clr = 1;
    step(s, -1);
    for (int k = 0; k < 3; k++) chk("clr_wins", k, fc_o[k], 32'd0);
    for (int i = 0; i < 3000; i++) begin
      s.r = $urandom_range(0, 49) == 0;
      s.busy = $urandom_range(0, 4) == 0;
      s.br = $urandom_range(0, 2) == 0;
      s.clr = $urandom_range(0, 39) == 0;
      s.mr = $urandom_range(0, 1) == 1;
      s.ex = 5'($urandom_range(0, 3));
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.urs = $urandom_range(0, 1) == 1;
      s.urt = $urandom_range(0, 1) == 1;
      step(s, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
